dvp_pattern_gen: RTL and testbench
==================================

DVP_PATTERN_GEN -- requirements
Module: dvp_pattern_gen

Purpose: synthesizable OV7670-style DVP transmitter, RGB565, driving camera_read inputs for bench and board bring-up without a camera.

Interface
REQ-001 Parameter H_PIXELS, default 640: active pixels per line; SHALL be a multiple of 8 and at most 1023.
REQ-002 Parameter V_LINES, default 480: active lines per frame; at most 511.
REQ-003 Parameter H_BLANK, default 144: pclk periods with href low after each active line.
REQ-004 Parameter VSYNC_LINES, default 3; V_BACK, default 17; V_FRONT, default 10: line counts.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  run frames while high.
REQ-008 mode  input  2  pattern select: 0 colour bars, 1 gradient, 2 solid, 3 checkerboard.
REQ-009 solid_color  input  16  RGB565 value for mode 2.
REQ-010 pclk  output  1  pixel clock, clk/2.
REQ-011 vsync  output  1  frame sync, active high.
REQ-012 href  output  1  line valid, active high.
REQ-013 data  output  8  pixel byte.
REQ-014 frame_done  output  1  one-clk pulse at end of frame.
REQ-015 frame_count  output  8  completed frames, wrapping.

Function
REQ-016 pclk SHALL toggle every clk cycle from the first edge after reset release.
REQ-017 vsync, href, data, and all counters SHALL change only on the clk edge where pclk goes 1->0, so they are stable at pclk rising edges.
REQ-018 Line length SHALL be 2*H_PIXELS + H_BLANK pclk periods.
- href is high for the first 2*H_PIXELS periods of active lines only.
REQ-019 FSM states SHALL be IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
- IDLE -> VSYNC at the first pclk-falling edge with enable=1.
- VSYNC -> VBACK after VSYNC_LINES lines; VBACK -> ACTIVE after V_BACK lines.
- ACTIVE -> VFRONT after V_LINES lines.
- VFRONT -> VSYNC (enable=1) or IDLE (enable=0) after V_FRONT lines.
REQ-020 vsync SHALL be 1 exactly while in VSYNC; href SHALL be 0 outside ACTIVE; data SHALL be 0 whenever href=0.
REQ-021 Each pixel SHALL be 2 bytes: first pixel[15:8], then pixel[7:0].
REQ-022 x (10 bits) counts pixels 0..H_PIXELS-1 within a line; y (9 bits) counts active lines 0..V_LINES-1.
REQ-023 Mode 0 SHALL output 8 bars, each H_PIXELS/8 wide, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index comes from a counter; no divider.
REQ-024 Mode 1 SHALL output pixel = {x[9:5], y[8:3], x[9:5]}.
REQ-025 Mode 2 SHALL output solid_color.
REQ-026 Mode 3 SHALL output FFFF when x[5]^y[5]^frame_count[0] = 1, else 0000.
REQ-027 mode and solid_color SHALL be latched on IDLE/VFRONT -> VSYNC entry and held constant for the whole frame.
REQ-028 Deasserting enable mid-frame SHALL NOT truncate the frame; the generator completes VFRONT and then enters IDLE.
REQ-029 At the final pclk-falling edge of the last VFRONT line, frame_done SHALL pulse for 1 clk and frame_count SHALL increment (255 -> 0 wrap).
REQ-030 A reset-first frame SHALL begin with vsync rising at most 2 clk after enable is sampled high.

Reset
REQ-031 While reset is high:
- pclk=0, vsync=0, href=0, data=0, frame_done=0, frame_count=0.
- State IDLE, all counters 0, latched mode=0, latched solid_color=0.
REQ-032 Reset asserted mid-frame SHALL force REQ-031 values immediately, with no partial-line completion.

Verification
Bench parameters: H_PIXELS=8, V_LINES=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1.
REQ-033 Basic frame: enable=1, mode=2, solid_color=ABCD.
- Per frame: 140 pclk periods (280 clk); vsync high for 20 periods.
- 4 href pulses of 16 periods each; bytes alternate AB, CD; frame_done every 280 clk.
REQ-034 Colour bars: mode 0.
- Each line's bytes: FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
REQ-035 Mid-frame mode change: switch mode 2 -> 0 during ACTIVE.
- Current frame stays solid; the next frame shows bars.
REQ-036 Enable drop: enable=0 on the third active line.
- Frame completes; frame_count +1; then IDLE with vsync=href=data=0 and pclk still toggling.
REQ-037 Reset during ACTIVE with href=1: all outputs 0 at once.
- After release with enable=1, vsync rises within 2 clk and frame_count=0.
REQ-038 Wrap and checkerboard: run 256 frames.
- frame_count wraps to 0.
- Mode 3 pixel (0,0) alternates 0000/FFFF between consecutive frames.

Source files
------------

// File: rtl/dvp_pattern_gen_if.sv
// Camera-side DVP bus: pattern controls into the generator, pixel clock, syncs and bytes out.
interface dvp_pattern_gen_if;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] solid_color;
    logic        pclk;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        frame_done;
    logic [7:0]  frame_count;

    modport master (
        input  enable, mode, solid_color,
        output pclk, vsync, href, data, frame_done, frame_count
    );

    modport slave (
        output enable, mode, solid_color,
        input  pclk, vsync, href, data, frame_done, frame_count
    );
endinterface

// File: rtl/dvp_pattern_gen.sv
// OV7670-style DVP transmitter producing RGB565 test patterns at pclk = clk/2.
// All frame state advances only on the clk edge where pclk falls.
module dvp_pattern_gen #(
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic              clk,
    input  logic              reset,
    dvp_pattern_gen_if.master bus
);
    localparam int LINE_LEN = 2 * H_PIXELS + H_BLANK;
    localparam int HW       = $clog2(LINE_LEN);
    localparam logic [HW-1:0] LINE_LAST = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] ACT_LEN   = HW'(2 * H_PIXELS);
    localparam logic [6:0]    BAR_LAST  = 7'(H_PIXELS / 8 - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t        state_q, state_d;
    logic          pclk_q;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [8:0]    lcnt_q, lcnt_d;
    logic [9:0]    x_q, x_d;
    logic [6:0]    barCnt_q, barCnt_d;
    logic [2:0]    barIdx_q, barIdx_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   solid_q, solid_d;
    logic [7:0]    frameCount_q, frameCount_d;
    logic          frameDone_q, frameDone_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    data_q, data_d;
    logic [15:0]   pixel;
    logic          lineEnd;
    logic          lastLine;

    function automatic logic [15:0] barColor(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    assign lineEnd = (hcnt_q == LINE_LAST);

    always_comb begin
        case (state_q)
            VSYNC:   lastLine = (lcnt_q == 9'(VSYNC_LINES - 1));
            VBACK:   lastLine = (lcnt_q == 9'(V_BACK - 1));
            ACTIVE:  lastLine = (lcnt_q == 9'(V_LINES - 1));
            VFRONT:  lastLine = (lcnt_q == 9'(V_FRONT - 1));
            default: lastLine = 1'b0;
        endcase
    end

    // Frame sequencing; mode and colour are captured only when a new frame starts.
    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        lcnt_d       = lcnt_q;
        mode_d       = mode_q;
        solid_d      = solid_q;
        frameCount_d = frameCount_q;
        frameDone_d  = 1'b0;
        if (state_q == IDLE) begin
            hcnt_d = '0;
            lcnt_d = '0;
            if (bus.enable) begin
                state_d = VSYNC;
                mode_d  = bus.mode;
                solid_d = bus.solid_color;
            end
        end else if (!lineEnd) begin
            hcnt_d = hcnt_q + 1'b1;
        end else begin
            hcnt_d = '0;
            lcnt_d = lastLine ? 9'd0 : lcnt_q + 1'b1;
            if (lastLine) begin
                case (state_q)
                    VSYNC:  state_d = VBACK;
                    VBACK:  state_d = ACTIVE;
                    ACTIVE: state_d = VFRONT;
                    default: begin
                        frameDone_d  = 1'b1;
                        frameCount_d = frameCount_q + 1'b1;
                        if (bus.enable) begin
                            state_d = VSYNC;
                            mode_d  = bus.mode;
                            solid_d = bus.solid_color;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Pixel position and bar index advance on each even byte slot instead of dividing x.
    always_comb begin
        x_d      = x_q;
        barCnt_d = barCnt_q;
        barIdx_d = barIdx_q;
        if (hcnt_d == '0) begin
            x_d      = '0;
            barCnt_d = '0;
            barIdx_d = '0;
        end else if (!hcnt_d[0]) begin
            x_d = x_q + 1'b1;
            if (barCnt_q == BAR_LAST) begin
                barCnt_d = '0;
                barIdx_d = barIdx_q + 1'b1;
            end else begin
                barCnt_d = barCnt_q + 1'b1;
            end
        end
        case (mode_d)
            2'd0:    pixel = barColor(barIdx_d);
            2'd1:    pixel = {x_d[9:5], lcnt_d[8:3], x_d[9:5]};
            2'd2:    pixel = solid_d;
            default: pixel = (x_d[5] ^ lcnt_d[5] ^ frameCount_q[0]) ? 16'hFFFF : 16'h0000;
        endcase
        vsync_d = (state_d == VSYNC);
        href_d  = (state_d == ACTIVE) && (hcnt_d < ACT_LEN);
        data_d  = href_d ? (hcnt_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pclk_q       <= 1'b0;
            state_q      <= IDLE;
            hcnt_q       <= '0;
            lcnt_q       <= '0;
            x_q          <= '0;
            barCnt_q     <= '0;
            barIdx_q     <= '0;
            mode_q       <= '0;
            solid_q      <= '0;
            frameCount_q <= '0;
            frameDone_q  <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
        end else begin
            pclk_q      <= ~pclk_q;
            frameDone_q <= 1'b0;
            if (pclk_q) begin
                state_q      <= state_d;
                hcnt_q       <= hcnt_d;
                lcnt_q       <= lcnt_d;
                x_q          <= x_d;
                barCnt_q     <= barCnt_d;
                barIdx_q     <= barIdx_d;
                mode_q       <= mode_d;
                solid_q      <= solid_d;
                frameCount_q <= frameCount_d;
                frameDone_q  <= frameDone_d;
                vsync_q      <= vsync_d;
                href_q       <= href_d;
                data_q       <= data_d;
            end
        end
    end

    assign bus.pclk        = pclk_q;
    assign bus.vsync       = vsync_q;
    assign bus.href        = href_q;
    assign bus.data        = data_q;
    assign bus.frame_done  = frameDone_q;
    assign bus.frame_count = frameCount_q;
endmodule

// File: tb/tb_dvp_pattern_gen.sv
// Self-checking bench for dvp_pattern_gen: frame-position model checked every cycle
// plus directed scenarios with literal expectations.
module tb_dvp_pattern_gen;
    localparam int HP = 8;
    localparam int VL = 4;
    localparam int HB = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int LINE  = 2 * HP + HB;
    localparam int FRAME = LINE * (VS + VB + VL + VF);

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] barColors [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                   16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [7:0]  barBytes [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                   8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    dvp_pattern_gen_if bus();

    dvp_pattern_gen #(
        .H_PIXELS(HP), .V_LINES(VL), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: position within the frame in pclk periods, advanced at each pclk fall.
    bit          mPclk = 1'b0;
    bit          mRun = 1'b0;
    bit          mDone = 1'b0;
    int          mP = 0;
    int          mFc = 0;
    logic [1:0]  mMode = 2'd0;
    logic [15:0] mSolid = 16'h0000;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPclk  <= 1'b0;
            mRun   <= 1'b0;
            mDone  <= 1'b0;
            mP     <= 0;
            mFc    <= 0;
            mMode  <= 2'd0;
            mSolid <= 16'h0000;
        end else begin
            mPclk <= !mPclk;
            mDone <= 1'b0;
            if (mPclk) begin
                if (!mRun) begin
                    if (bus.enable) begin
                        mRun   <= 1'b1;
                        mP     <= 0;
                        mMode  <= bus.mode;
                        mSolid <= bus.solid_color;
                    end
                end else if (mP == FRAME - 1) begin
                    mDone <= 1'b1;
                    mFc   <= (mFc + 1) % 256;
                    mP    <= 0;
                    if (bus.enable) begin
                        mMode  <= bus.mode;
                        mSolid <= bus.solid_color;
                    end else begin
                        mRun <= 1'b0;
                    end
                end else begin
                    mP <= mP + 1;
                end
            end
        end
    end

    function automatic logic [15:0] modelPixel(input int x, input int y);
        logic [15:0] p;
        case (mMode)
            2'd0:    p = barColors[3'(x / (HP / 8))];
            2'd1:    p = 16'(((x / 32) % 32) * 2048 + ((y / 8) % 64) * 32 + (x / 32) % 32);
            2'd2:    p = mSolid;
            default: p = ((((x / 32) % 2) ^ ((y / 32) % 2) ^ (mFc % 2)) != 0) ? 16'hFFFF : 16'h0000;
        endcase
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] md, input logic [15:0] sc);
        #1;
        reset           = rst;
        bus.enable      = en;
        bus.mode        = md;
        bus.solid_color = sc;
    endtask

    task automatic waitFrameDone(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_done !== 1'b1 && n < limit);
        checkOutput("frameDoneSeen", 32'(bus.frame_done), 32'd1);
    endtask

    task automatic waitHrefRise(input int limit);
        int   n;
        logic prev;
        bit   seen;
        n = 0;
        seen = 1'b0;
        prev = bus.href;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            seen = (bus.href === 1'b1 && prev === 1'b0);
            prev = bus.href;
        end
        checkOutput("hrefRiseSeen", 32'(seen), 32'd1);
    endtask

    task automatic sampleByte(output logic [7:0] d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.pclk !== 1'b1 && n < 4);
        d = bus.data;
    endtask

    task automatic measureFrame(input logic [15:0] pix, output int clks, output int vsClks,
                                output int hPulses, output int hClks, output int bytes, output int bad);
        logic prevH;
        logic [7:0] want;
        clks = 0; vsClks = 0; hPulses = 0; hClks = 0; bytes = 0; bad = 0;
        prevH = 1'b0;
        do begin
            @(negedge clk);
            clks++;
            if (bus.vsync === 1'b1) vsClks++;
            if (bus.href === 1'b1 && prevH === 1'b0) hPulses++;
            if (bus.href === 1'b1) hClks++;
            if (bus.href === 1'b1 && bus.pclk === 1'b1) begin
                want = bytes[0] ? pix[7:0] : pix[15:8];
                if (bus.data !== want) bad++;
                bytes++;
            end
            prevH = bus.href;
        end while (bus.frame_done !== 1'b1 && clks < 600);
    endtask

    // Continuous check of every output against the frame-position model.
    initial begin
        int line, col, aLine;
        logic eV, eH;
        logic [7:0] eD;
        logic [15:0] pix;
        forever begin
            @(negedge clk);
            line  = mP / LINE;
            col   = mP % LINE;
            aLine = line - VS - VB;
            eV = mRun && (line < VS);
            eH = mRun && (aLine >= 0) && (aLine < VL) && (col < 2 * HP);
            eD = 8'h00;
            if (eH) begin
                pix = modelPixel(col / 2, aLine);
                eD  = (col % 2 == 1) ? pix[7:0] : pix[15:8];
            end
            checkOutput("cycle pclk/vsync/href/data/done/count",
                        32'({bus.pclk, bus.vsync, bus.href, bus.data, bus.frame_done, bus.frame_count}),
                        32'({mPclk, eV, eH, eD, mDone, 8'(mFc)}));
        end
    end

    initial begin
        #2000000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int clks, vsClks, hPulses, hClks, bytes, bad, lat, quiet, toggles;
        logic prevPclk;

        applyStimulus(1'b1, 1'b0, 2'd2, 16'hABCD);
        repeat (2) @(negedge clk);
        checkOutput("resetOutputs",
                    32'({bus.pclk, bus.vsync, bus.href, bus.data, bus.frame_done, bus.frame_count}), 32'd0);

        applyStimulus(1'b0, 1'b1, 2'd2, 16'hABCD);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.vsync !== 1'b1 && lat < 4);
        checkOutput("vsyncWithin2Clk", 32'(lat <= 2 && bus.vsync === 1'b1), 32'd1);

        // Basic solid frame
        waitFrameDone(400);
        measureFrame(16'hABCD, clks, vsClks, hPulses, hClks, bytes, bad);
        checkOutput("frameClks", 32'(clks), 32'd280);
        checkOutput("vsyncClks", 32'(vsClks), 32'd40);
        checkOutput("hrefPulses", 32'(hPulses), 32'd4);
        checkOutput("hrefClks", 32'(hClks), 32'd128);
        checkOutput("solidBytes", 32'(bytes), 32'd64);
        checkOutput("solidBadBytes", 32'(bad), 32'd0);

        // Mode change during active: this frame stays solid, next shows bars
        waitHrefRise(200);
        applyStimulus(1'b0, 1'b1, 2'd0, 16'hABCD);
        measureFrame(16'hABCD, clks, vsClks, hPulses, hClks, bytes, bad);
        checkOutput("heldFrameBytes", 32'(bytes), 32'd64);
        checkOutput("heldFrameBadBytes", 32'(bad), 32'd0);
        waitHrefRise(200);
        for (int i = 0; i < 16; i++) begin
            sampleByte(b);
            checkOutput($sformatf("barByte%0d", i), 32'(b), 32'(barBytes[i]));
        end

        // Enable dropped on the third active line
        waitFrameDone(400);
        for (int i = 0; i < 3; i++) waitHrefRise(200);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'hABCD);
        waitFrameDone(400);
        quiet = 0;
        toggles = 0;
        prevPclk = bus.pclk;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.vsync !== 1'b0 || bus.href !== 1'b0 || bus.data !== 8'h00 || bus.frame_done !== 1'b0) quiet++;
            if (bus.pclk !== prevPclk) toggles++;
            prevPclk = bus.pclk;
        end
        checkOutput("idleQuiet", 32'(quiet), 32'd0);
        checkOutput("idlePclkToggles", 32'(toggles), 32'd300);

        // Reset while href is high
        applyStimulus(1'b0, 1'b1, 2'd0, 16'hABCD);
        waitHrefRise(300);
        checkOutput("hrefBeforeReset", 32'(bus.href), 32'd1);
        applyStimulus(1'b1, 1'b1, 2'd3, 16'hABCD);
        #1;
        checkOutput("resetMidLine",
                    32'({bus.pclk, bus.vsync, bus.href, bus.data, bus.frame_done, bus.frame_count}), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'd3, 16'hABCD);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.vsync !== 1'b1 && lat < 4);
        checkOutput("vsyncAfterReset", 32'(lat <= 2 && bus.vsync === 1'b1), 32'd1);
        checkOutput("frameCountAfterReset", 32'(bus.frame_count), 32'd0);

        // 256 checkerboard frames: pixel (0,0) alternates, counter wraps
        for (int f = 0; f < 256; f++) begin
            waitHrefRise(200);
            sampleByte(b);
            checkOutput("checkerPixel00", 32'(b), (f % 2 == 1) ? 32'hFF : 32'h00);
            waitFrameDone(400);
            if (f == 254) checkOutput("frameCount255", 32'(bus.frame_count), 32'd255);
        end
        checkOutput("frameCountWrap", 32'(bus.frame_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
